ocs_slot_scheduler: RTL and testbench
=====================================

Name: ocs_slot_scheduler

Overview:
- Time-slot master inside the OCS controller.
- Waits until every ToR control link reports ready and stays ready for a fixed time. It then issues one START command and runs an endless SLOT / CONFIG cycle.
- During CONFIG it drives the slot id consumed by the OCS switch modules. It issues a SYNC command to all ToRs at the start of every new slot.
- Commands go to the controller's per-channel frame builder over a valid/ready handshake.

Parameters:
- P_CHANNEL_NUM, 8, number of ToR links monitored.
- P_STABLE_CYCLES, 32'd256, consecutive cycles all links must be ready before START.
- P_SLOT_LEN, 32'h0000_04E2, SLOT phase length in cycles (must be >= 2).
- P_CONFIG_DELAY, 32'h0000_007D, CONFIG (OCS reconfiguration) length in cycles (must be >= 1).
- P_SLOT_NUM, 2, number of distinct slot ids; the id wraps from P_SLOT_NUM-1 to 0.
- P_SLOT_ID_W, 1, slot id width.

Ports:
- i_clk, input, 1, single clock domain.
- i_rst_n, input, 1, synchronous active-low reset.
- i_link_ready, input, P_CHANNEL_NUM, per-channel link/channel-up status.
- o_cmd_valid, output, 1, command valid.
- i_cmd_ready, input, 1, command accepted by frame builder.
- o_cmd_type, output, 2, 2'd1 = START, 2'd2 = SYNC, 2'd0 = none.
- o_cmd_slot_id, output, P_SLOT_ID_W, slot id carried in the command.
- o_cmd_time, output, 32, timestamp captured when the command was raised.
- o_slot_id, output, P_SLOT_ID_W, current OCS configuration id.
- o_slot_active, output, 1, high during the SLOT phase (ToRs may transmit).
- o_link_lost, output, 1, one-cycle pulse when a link drops after IDLE.
- o_sync_drop_cnt, output, 16, count of SYNC commands overwritten before acceptance; saturates.

Behaviour:
- Reset values: all outputs 0; state IDLE; time counter 0.
- Reset is synchronous; asserting it mid-operation returns to IDLE on the next edge.
- The time counter is free-running and 32-bit. It clears to 0 on the START handshake, then increments every cycle and wraps at 2^32.
- State IDLE: when &i_link_ready is 1, go to STABLE with the counter at 0.
- State STABLE: the counter increments while all links are ready. Any link low returns to IDLE with no o_link_lost pulse.
  - The counter reaching P_STABLE_CYCLES-1 moves to START. STABLE therefore lasts exactly P_STABLE_CYCLES cycles.
- State START: o_cmd_valid=1, type START, slot_id 0, time 0. These are held stable until i_cmd_ready.
  - On the handshake cycle: valid drops next cycle, state goes to SLOT, o_slot_id=0, o_slot_active=1.
- State SLOT: lasts exactly P_SLOT_LEN cycles with o_slot_active=1.
  - On its last cycle, the next edge enters CONFIG, o_slot_active=0 and o_slot_id advances (mod P_SLOT_NUM). All three change on the same edge.
- State CONFIG: lasts exactly P_CONFIG_DELAY cycles.
  - On the next edge the block enters SLOT, o_slot_active=1, and raises SYNC: o_cmd_valid=1, type SYNC, o_cmd_slot_id=o_slot_id, o_cmd_time=current time.
- SYNC is non-blocking; the slot timer never stalls.
  - If a SYNC is still pending when the next SYNC is due, the payload is overwritten and o_sync_drop_cnt increments, saturating at 16'hFFFF.
  - If i_cmd_ready and a new SYNC arrive in the same cycle, the old SYNC is accepted, the new one is loaded, and nothing is dropped.
- Link loss: any i_link_ready bit low while in START/SLOT/CONFIG causes the following on the next edge:
  - o_link_lost pulses for one cycle.
  - State goes to IDLE; o_cmd_valid, o_slot_active and o_slot_id clear to 0.
  - o_sync_drop_cnt is retained.
- Link loss has priority over the command handshake and phase transitions in the same cycle.
- The command payload never changes while o_cmd_valid=1 and i_cmd_ready=0, except on a SYNC overwrite.

Decomposition:
- Package ocs_pkg holds:
  - command type encodings CMD_NONE/CMD_START/CMD_SYNC;
  - the state enum IDLE/STABLE/START/SLOT/CONFIG;
  - the default P_SLOT_LEN/P_CONFIG_DELAY constants shared with the controller top.
- One sub-module, ocs_cmd_holdreg: a single-entry valid/ready command register with an overwrite input and a drop pulse output. The phase FSM and counters stay in the top.

Test Plan (bench params P_CHANNEL_NUM=8, P_STABLE_CYCLES=8, P_SLOT_LEN=10, P_CONFIG_DELAY=4, P_SLOT_NUM=2, ready tied 1 unless stated):
- Bring-up: links 8'hFF from cycle 0 → o_cmd_valid with type START, slot_id 0, time 0 is raised after exactly 8 STABLE cycles. After the handshake, o_slot_active=1 for 10 cycles.
- Periodicity: run 3 slots → o_slot_id sequence 0,1,0. o_slot_active period 14 cycles with high time 10. Each SYNC appears on the first SLOT cycle with o_cmd_time=14·k and slot_id matching o_slot_id.
- Stable glitch: link 3 low for 1 cycle at STABLE count 5 → back to IDLE, no o_link_lost, START delayed by a full 8 cycles after recovery.
- Backpressure: i_cmd_ready=0 for 20 cycles after the first SYNC → the second SYNC overwrites it with slot_id 0 and time 28, and o_sync_drop_cnt=1. The slot timing is unchanged.
- Link drop mid-SLOT: clear link 7 at SLOT cycle 4 → one o_link_lost pulse; next cycle o_slot_active=0, o_slot_id=0, o_cmd_valid=0, state IDLE. The sequence restarts with START.
- Reset mid-CONFIG: i_rst_n=0 for 1 cycle → all outputs 0 on the next edge; o_sync_drop_cnt cleared.

Source files
------------

// File: rtl/ocs_pkg.sv
// Shared encodings and default timing constants for the OCS slot scheduler
// and the controller top that instantiates it.
package ocs_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_START = 2'd1,
    CMD_SYNC  = 2'd2
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STABLE = 3'd1,
    ST_START  = 3'd2,
    ST_SLOT   = 3'd3,
    ST_CONFIG = 3'd4
  } ocs_state_e;

  localparam logic [31:0] OCS_SLOT_LEN_DEFAULT     = 32'h0000_04E2;
  localparam logic [31:0] OCS_CONFIG_DELAY_DEFAULT = 32'h0000_007D;

endpackage

// File: rtl/ocs_slot_scheduler_if.sv
// Command channel from the slot scheduler to the per-channel frame builder.
interface ocs_slot_scheduler_if #(
  parameter int P_SLOT_ID_W = 1
) ();
  // A command transfers on a cycle where cmd_valid and cmd_ready are both high;
  // the payload holds while valid is high and ready is low (except a SYNC overwrite).
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_type;
  logic [P_SLOT_ID_W-1:0] cmd_slot_id;
  logic [31:0]            cmd_time;

  modport master (
    output cmd_valid, cmd_type, cmd_slot_id, cmd_time,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_slot_id, cmd_time,
    output cmd_ready
  );
endinterface

// File: rtl/ocs_cmd_holdreg.sv
// Single-entry command register: a load while still holding an unaccepted
// entry replaces it and flags a drop.
module ocs_cmd_holdreg
  import ocs_pkg::*;
#(
  parameter int P_SLOT_ID_W = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   load_i,
  input  logic [1:0]             load_type_i,
  input  logic [P_SLOT_ID_W-1:0] load_slot_i,
  input  logic [31:0]            load_time_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [1:0]             type_o,
  output logic [P_SLOT_ID_W-1:0] slot_o,
  output logic [31:0]            time_o,
  output logic                   drop_o
);

  logic                   valid_q, valid_d;
  logic [1:0]             type_q, type_d;
  logic [P_SLOT_ID_W-1:0] slot_q, slot_d;
  logic [31:0]            time_q, time_d;

  always_comb begin
    valid_d = valid_q;
    type_d  = type_q;
    slot_d  = slot_q;
    time_d  = time_q;
    drop_o  = 1'b0;
    if (clear_i) begin
      valid_d = 1'b0;
      type_d  = CMD_NONE;
      slot_d  = '0;
      time_d  = '0;
    end else if (load_i) begin
      // An entry accepted on this same edge is not a drop.
      drop_o  = valid_q & ~ready_i;
      valid_d = 1'b1;
      type_d  = load_type_i;
      slot_d  = load_slot_i;
      time_d  = load_time_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      type_d  = CMD_NONE;
      slot_d  = '0;
      time_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      type_q  <= CMD_NONE;
      slot_q  <= '0;
      time_q  <= '0;
    end else begin
      valid_q <= valid_d;
      type_q  <= type_d;
      slot_q  <= slot_d;
      time_q  <= time_d;
    end
  end

  assign valid_o = valid_q;
  assign type_o  = type_q;
  assign slot_o  = slot_q;
  assign time_o  = time_q;

endmodule

// File: rtl/ocs_slot_scheduler.sv
// OCS time-slot master: waits for stable links, sends START, then runs the
// endless SLOT/CONFIG cycle and issues a SYNC at the start of each new slot.
module ocs_slot_scheduler
  import ocs_pkg::*;
#(
  parameter int          P_CHANNEL_NUM   = 8,
  parameter logic [31:0] P_STABLE_CYCLES = 32'd256,
  parameter logic [31:0] P_SLOT_LEN      = OCS_SLOT_LEN_DEFAULT,
  parameter logic [31:0] P_CONFIG_DELAY  = OCS_CONFIG_DELAY_DEFAULT,
  parameter int          P_SLOT_NUM      = 2,
  parameter int          P_SLOT_ID_W     = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [P_CHANNEL_NUM-1:0] i_link_ready,
  ocs_slot_scheduler_if.master     cmd,
  output logic [P_SLOT_ID_W-1:0]   o_slot_id,
  output logic                     o_slot_active,
  output logic                     o_link_lost,
  output logic [15:0]              o_sync_drop_cnt,
  output logic [2:0]               o_dbg_state
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_STABLE = ST_STABLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_SLOT   = ST_SLOT;
  localparam logic [2:0] S_CONFIG = ST_CONFIG;

  logic [2:0]             state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            time_q, time_d;
  logic [P_SLOT_ID_W-1:0] slot_id_q, slot_id_d;
  logic                   active_q, active_d;
  logic                   link_lost_q, link_lost_d;
  logic [15:0]            drop_cnt_q;

  logic                   all_ready;
  logic                   ld, clr, hold_drop;
  logic [1:0]             ld_type;
  logic [P_SLOT_ID_W-1:0] ld_slot;
  logic [31:0]            ld_time;

  assign all_ready = &i_link_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    time_d      = time_q + 32'd1;
    slot_id_d   = slot_id_q;
    active_d    = active_q;
    link_lost_d = 1'b0;
    ld          = 1'b0;
    clr         = 1'b0;
    ld_type     = CMD_NONE;
    ld_slot     = '0;
    ld_time     = '0;
    case (state_q)
      S_IDLE: begin
        if (all_ready) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end
      end
      S_STABLE: begin
        if (!all_ready) begin
          state_d = S_IDLE;
        end else if (cnt_q == P_STABLE_CYCLES - 32'd1) begin
          state_d = S_START;
          ld      = 1'b1;
          ld_type = CMD_START;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_START, S_SLOT, S_CONFIG: begin
        // Link loss outranks the handshake and any phase boundary.
        if (!all_ready) begin
          state_d     = S_IDLE;
          link_lost_d = 1'b1;
          active_d    = 1'b0;
          slot_id_d   = '0;
          cnt_d       = '0;
          clr         = 1'b1;
        end else if (state_q == S_START) begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            state_d   = S_SLOT;
            active_d  = 1'b1;
            slot_id_d = '0;
            cnt_d     = '0;
            time_d    = '0;
          end
        end else if (state_q == S_SLOT) begin
          if (cnt_q == P_SLOT_LEN - 32'd1) begin
            state_d   = S_CONFIG;
            active_d  = 1'b0;
            cnt_d     = '0;
            slot_id_d = (slot_id_q == P_SLOT_ID_W'(P_SLOT_NUM - 1)) ? '0
                                                                    : slot_id_q + P_SLOT_ID_W'(1);
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else begin
          if (cnt_q == P_CONFIG_DELAY - 32'd1) begin
            state_d  = S_SLOT;
            active_d = 1'b1;
            cnt_d    = '0;
            ld       = 1'b1;
            ld_type  = CMD_SYNC;
            ld_slot  = slot_id_q;
            ld_time  = time_d;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      time_q      <= '0;
      slot_id_q   <= '0;
      active_q    <= 1'b0;
      link_lost_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      time_q      <= time_d;
      slot_id_q   <= slot_id_d;
      active_q    <= active_d;
      link_lost_q <= link_lost_d;
      if (hold_drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  ocs_cmd_holdreg #(.P_SLOT_ID_W(P_SLOT_ID_W)) u_holdreg (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .clear_i     (clr),
    .load_i      (ld),
    .load_type_i (ld_type),
    .load_slot_i (ld_slot),
    .load_time_i (ld_time),
    .ready_i     (cmd.cmd_ready),
    .valid_o     (cmd.cmd_valid),
    .type_o      (cmd.cmd_type),
    .slot_o      (cmd.cmd_slot_id),
    .time_o      (cmd.cmd_time),
    .drop_o      (hold_drop)
  );

  assign o_slot_id       = slot_id_q;
  assign o_slot_active   = active_q;
  assign o_link_lost     = link_lost_q;
  assign o_sync_drop_cnt = drop_cnt_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_ocs_slot_scheduler.sv
// Bench for ocs_slot_scheduler: timeline model checked every cycle plus
// directed bring-up, periodicity, backpressure, glitch, link-drop and reset cases.
module tb_ocs_slot_scheduler;
  import ocs_pkg::*;

  localparam int TB_STABLE = 8;
  localparam int TB_SLOT   = 10;
  localparam int TB_CFG    = 4;
  localparam int TB_PERIOD = TB_SLOT + TB_CFG;
  localparam int TB_SLOTS  = 2;
  localparam int M_WAIT    = 0;
  localparam int M_START   = 1;
  localparam int M_RUN     = 2;

  // clock / reset / inputs
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] link = 8'hFF;
  logic       cmd_ready = 1'b1;

  logic [0:0] slot_id;
  logic       slot_active, link_lost;
  logic [15:0] drop_cnt;
  logic [2:0] dbg_state;

  ocs_slot_scheduler_if #(.P_SLOT_ID_W(1)) cmd_if ();
  assign cmd_if.cmd_ready = cmd_ready;

  ocs_slot_scheduler #(
    .P_CHANNEL_NUM   (8),
    .P_STABLE_CYCLES (32'(TB_STABLE)),
    .P_SLOT_LEN      (32'(TB_SLOT)),
    .P_CONFIG_DELAY  (32'(TB_CFG)),
    .P_SLOT_NUM      (TB_SLOTS),
    .P_SLOT_ID_W     (1)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_link_ready    (link),
    .cmd             (cmd_if),
    .o_slot_id       (slot_id),
    .o_slot_active   (slot_active),
    .o_link_lost     (link_lost),
    .o_sync_drop_cnt (drop_cnt),
    .o_dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- behavioural model: link-stability run, time since START, pending command
  int          m_mode = M_WAIT;
  int          m_run  = 0;
  int          m_t    = 0;
  logic        m_pv   = 1'b0;
  logic [1:0]  m_ptype = 2'd0;
  logic [31:0] m_pslot = '0;
  logic [31:0] m_ptime = '0;
  logic [15:0] m_drops = '0;
  logic        m_lost  = 1'b0;
  bit          model_live = 1'b0;

  task automatic model_lose();
    m_mode = M_WAIT;
    m_run  = 0;
    m_pv   = 1'b0;
    m_lost = 1'b1;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_mode = M_WAIT; m_run = 0; m_t = 0; m_pv = 1'b0;
      m_drops = '0; m_lost = 1'b0;
    end else begin
      m_lost = 1'b0;
      if (m_mode == M_WAIT) begin
        // one IDLE observation plus TB_STABLE stable cycles, all links up
        if (&link) begin
          m_run++;
          if (m_run == TB_STABLE + 1) begin
            m_mode = M_START; m_pv = 1'b1; m_ptype = 2'd1; m_pslot = 0; m_ptime = 0;
          end
        end else m_run = 0;
      end else if (!(&link)) begin
        model_lose();
      end else if (m_mode == M_START) begin
        if (cmd_ready) begin m_pv = 1'b0; m_mode = M_RUN; m_t = 0; end
      end else begin
        if (m_pv && cmd_ready) m_pv = 1'b0;
        m_t++;
        if (m_t % TB_PERIOD == 0) begin
          if (m_pv && m_drops != 16'hFFFF) m_drops++;
          m_pv = 1'b1; m_ptype = 2'd2;
          m_pslot = 32'((m_t / TB_PERIOD) % TB_SLOTS);
          m_ptime = 32'(m_t);
        end
      end
    end
  endtask

  function automatic logic exp_active();
    return (m_mode == M_RUN) && ((m_t % TB_PERIOD) < TB_SLOT);
  endfunction

  function automatic logic [31:0] exp_slot();
    if (m_mode != M_RUN) return 32'd0;
    return 32'(((m_t / TB_PERIOD) + (((m_t % TB_PERIOD) >= TB_SLOT) ? 1 : 0)) % TB_SLOTS);
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
    model_live = 1'b1;
  end

  // ---- compare process (negedge, away from the active edge)
  initial forever begin
    @(negedge clk);
    if (model_live) begin
      check("cmd_valid", cmd_if.cmd_valid, m_pv);
      if (m_pv) begin
        check("cmd_type", cmd_if.cmd_type, m_ptype);
        check("cmd_slot_id", cmd_if.cmd_slot_id, m_pslot);
        check("cmd_time", cmd_if.cmd_time, m_ptime);
      end
      check("slot_active", slot_active, exp_active());
      check("slot_id", slot_id, exp_slot());
      check("link_lost", link_lost, m_lost);
      check("sync_drop_cnt", drop_cnt, m_drops);
    end
  end

  // ---- directed stimulus with hand-computed expectations
  initial begin
    int n;
    int cnt_active;
    int lost_seen;
    rst_n = 1'b0; link = 8'hFF; cmd_ready = 1'b1;
    tick(); tick();
    check("rst_cmd_valid", cmd_if.cmd_valid, 0);
    check("rst_cmd_type", cmd_if.cmd_type, 0);
    check("rst_cmd_slot", cmd_if.cmd_slot_id, 0);
    check("rst_cmd_time", cmd_if.cmd_time, 0);
    check("rst_slot_id", slot_id, 0);
    check("rst_slot_active", slot_active, 0);
    check("rst_link_lost", link_lost, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // bring-up: IDLE cycle + 8 STABLE cycles before START
    rst_n = 1'b1;
    n = 0;
    while (!cmd_if.cmd_valid && n < 50) begin tick(); n++; end
    check("bringup_latency", n, 9);
    check("start_type", cmd_if.cmd_type, 1);
    check("start_slot", cmd_if.cmd_slot_id, 0);
    check("start_time", cmd_if.cmd_time, 0);
    tick();

    // periodicity with backpressure across the first SYNC
    cnt_active = 0;
    for (int i = 0; i <= 42; i++) begin
      if (i == 13) cmd_ready = 1'b0;
      if (i == 33) cmd_ready = 1'b1;
      if (i < 42 && slot_active) cnt_active++;
      if (i == 0) begin check("p0_slot_id", slot_id, 0); check("p0_active", slot_active, 1); end
      if (i == 9) check("p9_active", slot_active, 1);
      if (i == 10) begin check("p10_active", slot_active, 0); check("p10_slot_id", slot_id, 1); end
      if (i == 14) begin
        check("sync1_valid", cmd_if.cmd_valid, 1);
        check("sync1_type", cmd_if.cmd_type, 2);
        check("sync1_slot", cmd_if.cmd_slot_id, 1);
        check("sync1_time", cmd_if.cmd_time, 14);
        check("p14_slot_id", slot_id, 1);
      end
      if (i == 28) begin
        check("sync2_valid", cmd_if.cmd_valid, 1);
        check("sync2_slot", cmd_if.cmd_slot_id, 0);
        check("sync2_time", cmd_if.cmd_time, 28);
        check("sync2_drop", drop_cnt, 1);
        check("p28_slot_id", slot_id, 0);
      end
      if (i == 42) begin
        check("sync3_slot", cmd_if.cmd_slot_id, 1);
        check("sync3_time", cmd_if.cmd_time, 42);
        check("sync3_drop", drop_cnt, 1);
      end
      if (i < 42) tick();
    end
    check("active_high_cycles", cnt_active, 30);

    // link 7 drops at SLOT cycle 4
    tick(); tick(); tick(); tick();
    link[7] = 1'b0;
    tick();
    check("drop_link_lost", link_lost, 1);
    check("drop_active", slot_active, 0);
    check("drop_slot_id", slot_id, 0);
    check("drop_cmd_valid", cmd_if.cmd_valid, 0);
    check("drop_state", dbg_state, ST_IDLE);
    check("drop_cnt_kept", drop_cnt, 1);
    link = 8'hFF;

    // restart with a one-cycle glitch on link 3 at STABLE count 5
    n = 0;
    lost_seen = 0;
    while (!cmd_if.cmd_valid && n < 60) begin
      tick(); n++;
      if (link_lost) lost_seen++;
      if (n == 6) link[3] = 1'b0;
      if (n == 7) link = 8'hFF;
    end
    check("glitch_start_latency", n, 16);
    check("glitch_no_link_lost", lost_seen, 0);
    check("restart_type", cmd_if.cmd_type, 1);
    tick();

    // reset in the middle of CONFIG
    for (int i = 0; i < 11; i++) tick();
    check("cfg_active", slot_active, 0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", cmd_if.cmd_valid, 0);
    check("mid_rst_slot_id", slot_id, 0);
    check("mid_rst_active", slot_active, 0);
    check("mid_rst_drop_cnt", drop_cnt, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
